// File: rtl/pent_pkg.sv
// Shared types and constants for the Pentagon-style CPU/video RAM arbiter.
package pent_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    // Clocks from the grant edge to the closing edge of the ack cycle.
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR_A = 3'd3,
        WR_W = 3'd4,
        WR_H = 3'd5
    } state_e;

endpackage

// File: rtl/pent_req_latch.sv
// One-deep request holding register: a strobe captures the payload and sets pend;
// a strobe that finds pend already set (and not being granted) is dropped and flagged.
module pent_req_latch #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    output logic         pend_o,
    output logic         pend_d_o,
    output logic [W-1:0] data_o,
    output logic         ovf_o
);

    logic         pend_q, pend_d;
    logic [W-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;
    logic         accept;

    // A grant in the same cycle frees the slot, so the new strobe takes it.
    always_comb begin
        accept = req_i && (!pend_q || clr_i);
        pend_d = accept || (pend_q && !clr_i);
        data_d = accept ? data_i : data_q;
        ovf_d  = ovf_q || (req_i && pend_q && !clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend_o   = pend_q;
    assign pend_d_o = pend_d;
    assign data_o   = data_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/pent_mem_arb.sv
// Round-robin arbiter sharing one asynchronous SRAM between CPU and video fetch.
// All RAM control outputs are registered from the next state so they are glitch-free.
import pent_pkg::*;

module pent_mem_arb #(
    parameter bit VID_FIRST = 1'b1
) (
    input  logic              CLK_14MHZ,
    input  logic              CPU_RESET,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    output logic              vid_ovf,
    output logic [ADDR_W-1:0] ma,
    input  logic [DATA_W-1:0] md_in,
    output logic [DATA_W-1:0] md_out,
    output logic              md_oe,
    output logic              cs_n,
    output logic              we_n
);

    localparam int CPU_W = 1 + ADDR_W + DATA_W;

    logic              vid_pend, vid_pend_nx_unused, vid_clr;
    logic [ADDR_W-1:0] vid_addr_q;
    logic              cpu_pend, cpu_pend_d, cpu_clr, cpu_ovf_unused;
    logic [CPU_W-1:0]  cpu_pay_q;
    logic              cpu_wr_q;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic [DATA_W-1:0] cpu_wdata_q;

    state_e            state_q, state_d;
    logic              grant_cpu_q, grant_cpu_d;
    logic              prefer_vid_q, prefer_vid_d;
    logic [ADDR_W-1:0] ma_q;
    logic [DATA_W-1:0] md_out_q, cpu_rdata_q, vid_rdata_q;
    logic              md_oe_q, cs_n_q, we_n_q, cpu_ack_q, vid_ack_q, cpu_wait_n_q;

    pent_req_latch #(.W(ADDR_W)) u_vid_latch (
        .clk      (CLK_14MHZ),
        .rst_n    (CPU_RESET),
        .req_i    (vid_req),
        .clr_i    (vid_clr),
        .data_i   (vid_addr),
        .pend_o   (vid_pend),
        .pend_d_o (vid_pend_nx_unused),
        .data_o   (vid_addr_q),
        .ovf_o    (vid_ovf)
    );

    pent_req_latch #(.W(CPU_W)) u_cpu_latch (
        .clk      (CLK_14MHZ),
        .rst_n    (CPU_RESET),
        .req_i    (cpu_req),
        .clr_i    (cpu_clr),
        .data_i   ({cpu_wr, cpu_addr, cpu_wdata}),
        .pend_o   (cpu_pend),
        .pend_d_o (cpu_pend_d),
        .data_o   (cpu_pay_q),
        .ovf_o    (cpu_ovf_unused)
    );

    assign {cpu_wr_q, cpu_addr_q, cpu_wdata_q} = cpu_pay_q;

    always_comb begin
        state_d      = state_q;
        grant_cpu_d  = grant_cpu_q;
        prefer_vid_d = prefer_vid_q;
        vid_clr      = 1'b0;
        cpu_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                // prefer_vid_q only matters on a tie; it always points at the loser of the last grant.
                if (vid_pend && (!cpu_pend || prefer_vid_q)) begin
                    vid_clr      = 1'b1;
                    grant_cpu_d  = 1'b0;
                    prefer_vid_d = 1'b0;
                    state_d      = RD_A;
                end else if (cpu_pend) begin
                    cpu_clr      = 1'b1;
                    grant_cpu_d  = 1'b1;
                    prefer_vid_d = 1'b1;
                    state_d      = cpu_wr_q ? WR_A : RD_A;
                end
            end
            RD_A:    state_d = RD_D;
            RD_D:    state_d = IDLE;
            WR_A:    state_d = WR_W;
            WR_W:    state_d = WR_H;
            WR_H:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            state_q      <= IDLE;
            grant_cpu_q  <= 1'b0;
            prefer_vid_q <= VID_FIRST;
            ma_q         <= '0;
            md_out_q     <= '0;
            md_oe_q      <= 1'b0;
            cs_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_wait_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_cpu_q  <= grant_cpu_d;
            prefer_vid_q <= prefer_vid_d;
            cs_n_q       <= (state_d == IDLE);
            we_n_q       <= (state_d != WR_W);
            md_oe_q      <= (state_d == WR_A) || (state_d == WR_W) || (state_d == WR_H);
            if (vid_clr) begin
                ma_q <= vid_addr_q;
            end
            if (cpu_clr) begin
                ma_q <= cpu_addr_q;
                if (cpu_wr_q) begin
                    md_out_q <= cpu_wdata_q;
                end
            end
            if (state_q == RD_D) begin
                if (grant_cpu_q) begin
                    cpu_rdata_q <= md_in;
                end else begin
                    vid_rdata_q <= md_in;
                end
            end
            vid_ack_q    <= !grant_cpu_q && (state_q == RD_D);
            cpu_ack_q    <= grant_cpu_q && ((state_q == RD_D) || (state_q == WR_H));
            cpu_wait_n_q <= !(cpu_pend_d || (grant_cpu_d && (state_d != IDLE)));
        end
    end

    assign ma         = ma_q;
    assign md_out     = md_out_q;
    assign md_oe      = md_oe_q;
    assign cs_n       = cs_n_q;
    assign we_n       = we_n_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_rdata  = vid_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_wait_n = cpu_wait_n_q;

endmodule

// File: doc/pent_mem_arb.md
PENT_MEM_ARB -- requirements
Module: pent_mem_arb

Interface
REQ-001 SHALL have ports: CLK_14MHZ  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: CPU_RESET  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cpu_req  in  1  one-clock strobe requesting one CPU access.
REQ-004 SHALL have ports: cpu_wr  in  1 (1 = write); cpu_addr  in  19; cpu_wdata  in  8. All three are sampled with cpu_req.
REQ-005 SHALL have ports: cpu_rdata  out  8  read data; cpu_ack  out  1  one-clock completion strobe; cpu_wait_n  out  1  low while a CPU access is pending or in progress.
REQ-006 SHALL have ports: vid_req  in  1  strobe; vid_addr  in  19; vid_rdata  out  8; vid_ack  out  1; vid_ovf  out  1  sticky overflow flag.
REQ-007 SHALL have ports: ma  out  19  RAM address; md_in  in  8; md_out  out  8; md_oe  out  1  drive md_out onto MD; cs_n  out  1; we_n  out  1.
REQ-008 SHALL have parameter VID_FIRST, default 1, meaning video wins the first tie after reset.

Function
REQ-009 SHALL latch each requester's address, and for the CPU also cpu_wr and cpu_wdata, into a pending register on its strobe, and set that requester's pend flag.
REQ-010 SHALL, when a strobe arrives while that requester's pend flag is already set, ignore the strobe; a video strobe in this case also sets vid_ovf, which clears only on reset.
REQ-011 SHALL, when a strobe arrives in the same cycle as its own grant, let the grant consume the old request and let the new strobe re-set pend with the new data.
REQ-012 SHALL implement the FSM states IDLE, RD_A, RD_D, WR_A, WR_W, WR_H.
REQ-013 SHALL decide arbitration only in IDLE, using the pend flags registered at that edge.
REQ-014 SHALL, in IDLE with exactly one pend set, grant that requester.
REQ-015 SHALL, in IDLE with both pend set, grant the requester not granted last (round robin); the tie-break register takes VID_FIRST at reset.
REQ-016 SHALL route a video grant or a CPU read grant through IDLE->RD_A->RD_D->IDLE, and a CPU write grant through IDLE->WR_A->WR_W->WR_H->IDLE.
REQ-017 SHALL hold ma at the granted latched address and cs_n=0 throughout RD_A/RD_D/WR_A/WR_W/WR_H; in IDLE, cs_n=1 and ma holds its last value.
REQ-018 SHALL keep we_n=0 only in WR_W, with md_oe=1 and md_out=latched wdata in WR_A, WR_W and WR_H; md_oe=0 in all other states.
REQ-019 SHALL capture md_in into vid_rdata or cpu_rdata on the rising edge that ends RD_D; rdata holds until the next read of the same requester.
REQ-020 SHALL pulse the granted ack for exactly one clock in the IDLE cycle that follows RD_D or WR_H.
REQ-021 SHALL therefore give a read a latency of 3 clocks from grant-edge to ack and a write a latency of 4 clocks; an uncontended CPU read strobed at edge k has ack high in cycle k+4.
REQ-022 SHALL allow back-to-back accesses: the IDLE cycle carrying an ack is also an arbitration cycle, so the next grant goes out at its closing edge.
REQ-023 SHALL drive cpu_wait_n = NOT(cpu pend OR a CPU grant in progress), registered, rising in the same cycle as cpu_ack.
REQ-024 SHALL wrap no counters or addresses; addresses pass through unmodified at 19 bits.

Reset
REQ-025 SHALL, on CPU_RESET low, immediately force: state=IDLE, both pend=0, vid_ovf=0, cs_n=1, we_n=1, md_oe=0, ma=0, md_out=0, both rdata=0, both ack=0, cpu_wait_n=1.
REQ-026 SHALL abort an access in progress when reset asserts mid-operation, including during WR_W, where we_n goes high asynchronously; no ack is issued for an aborted access.
REQ-027 SHALL ignore strobes in the cycle reset deasserts only if they coincide with the deassert edge; the first edge after deassertion samples normally.

Structure
REQ-028 SHALL place the FSM state encoding and constants RD_LAT=3 and WR_LAT=4 in shared package pent_pkg.
REQ-029 SHALL instantiate one sub-module per requester, pent_req_latch: strobe->pend/addr/data holding register with overflow detect; the arbiter FSM stays in pent_mem_arb.

Verification
REQ-030 SHALL cover: single CPU read, addr 19'h05A3C, md_in=8'hC9 during RD_D -> cs_n low for 2 clocks, cpu_rdata=8'hC9, cpu_ack 4 clocks after strobe, cpu_wait_n low for 3 cycles.
REQ-031 SHALL cover: CPU write, addr 19'h7FFFF, wdata=8'hA5 -> we_n low exactly 1 clock (WR_W), md_oe high 3 clocks, md_out=8'hA5, ack 5 clocks after strobe.
REQ-032 SHALL cover: vid_req and cpu_req strobed in the same cycle after reset -> video granted first, CPU granted at the video ack cycle, cpu_ack 3 clocks after vid_ack.
REQ-033 SHALL cover: two vid_req strobes 1 clock apart while the first is still pending -> second ignored, vid_ovf=1 until reset, one vid_ack only.
REQ-034 SHALL cover: CPU_RESET asserted during WR_W -> we_n=1, cs_n=1, md_oe=0 within the same cycle, no cpu_ack, cpu_wait_n=1.
REQ-035 SHALL cover: continuous alternating strobes from both requesters for 100 accesses -> strict alternation of grants, no starvation, zero idle cycles between accesses.
